// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared types and constants for the Goldschmidt divider controller
//   state_t        : controller FSM states
//   GS_W, GS_PW    : operand width (Q1.15) and product width (Q2.30)
//   PROD_HI/LO     : product bits that form the next Q1.15 operand (truncated)
//   DIVZERO_Q      : quotient reported for a zero divisor (GS_DIVZERO_EN builds)
package gs_pkg;

   localparam int GS_W    = 16;
   localparam int GS_PW   = 2 * GS_W;
   localparam int CNT_W   = 4;
   localparam int PROD_HI = 30;
   localparam int PROD_LO = 15;

   localparam logic [GS_W-1:0] DIVZERO_Q = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_D,
      S_ISSUE_N,
      S_DRAIN,
      S_CAPTURE
   } state_t;

   // Q2.30 -> Q1.15; bit 31 is dropped and no rounding is applied.
   function automatic logic [GS_W-1:0] prod_slice(input logic [GS_PW-1:0] p);
      return p[PROD_HI:PROD_LO];
   endfunction

endpackage

// File: rtl/gs_iter_counter.sv
// rtl/gs_iter_counter.sv - loadable iteration counter with terminal-count flag
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : load zero (wins over inc_i)
//   inc_i    : advance by one
//   cnt_o    : current count
//   tc_o     : count equals LAST
module gs_iter_counter #(
   parameter int CW   = 4,
   parameter int LAST = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == CW'(LAST));

endmodule

// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - sequencing controller driving the Goldschmidt divider datapath
//   clk, reset       : clock, asynchronous active-high reset
//   start            : division request, sampled only while idle
//   nIn, dIn         : dividend / divisor, Q1.15
//   result           : datapath product register, Q2.30
//   kSelect          : 0 selects IA as k, 1 derives k from result
//   ndSelect         : 0 issues D (k register loads), 1 issues N (k held)
//   nOut, dOut       : operands to the datapath, zero when not issuing
//   busy, done, q    : in-progress flag, one-cycle completion pulse, held quotient
//   divzero          : zero-divisor flag, only active when GS_DIVZERO_EN is defined
module goldschmidt_ctrl
   import gs_pkg::*;
#(
   parameter int ITER = 4,
   parameter int W    = GS_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   nIn,
   input  logic [W-1:0]   dIn,
   input  logic [2*W-1:0] result,
   output logic           kSelect,
   output logic           ndSelect,
   output logic [W-1:0]   nOut,
   output logic [W-1:0]   dOut,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   q,
   output logic           divzero
);

   state_t             state_q, state_d;
   logic [W-1:0]       n_q, n_d;
   logic [W-1:0]       d_q, d_d;
   logic [W-1:0]       q_q, q_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;
   logic               cnt_clr, cnt_inc, cnt_tc;
   logic [CNT_W-1:0]   iter;
   logic [W-1:0]       prod;
   logic               unused_prod_bits;

   assign prod             = prod_slice(result);
   assign unused_prod_bits = ^{result[2*W-1], result[PROD_LO-1:0]};

   gs_iter_counter #(
      .CW   (CNT_W),
      .LAST (ITER - 1)
   ) u_iter (
      .clk   (clk),
      .rst   (reset),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .cnt_o (iter),
      .tc_o  (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      d_d       = d_q;
      q_d       = q_q;
      done_d    = 1'b0;
      divzero_d = divzero_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      kSelect   = 1'b0;
      ndSelect  = 1'b0;
      nOut      = '0;
      dOut      = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d       = nIn;
               d_d       = dIn;
               cnt_clr   = 1'b1;
               divzero_d = 1'b0;
`ifdef GS_DIVZERO_EN
               if (dIn == '0) begin
                  // Bypass the iterations entirely and report saturation.
                  q_d       = DIVZERO_Q;
                  divzero_d = 1'b1;
                  done_d    = 1'b1;
               end else begin
                  state_d = S_ISSUE_D;
               end
`else
               state_d = S_ISSUE_D;
`endif
            end
         end
         S_ISSUE_D: begin
            // From iteration 1 on, result holds the previous D product.
            kSelect = (iter != '0);
            dOut    = (iter == '0) ? d_q : prod;
            state_d = S_ISSUE_N;
         end
         S_ISSUE_N: begin
            ndSelect = 1'b1;
            kSelect  = (iter != '0);
            nOut     = (iter == '0) ? n_q : prod;
            if (cnt_tc) begin
               state_d = S_DRAIN;
            end else begin
               cnt_inc = 1'b1;
               state_d = S_ISSUE_D;
            end
         end
         S_DRAIN: begin
            // Wait for the last N product; keep the k register frozen.
            ndSelect = 1'b1;
            state_d  = S_CAPTURE;
         end
         S_CAPTURE: begin
            ndSelect = 1'b1;
            q_d      = prod;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         d_q       <= '0;
         q_q       <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         d_q       <= d_d;
         q_q       <= q_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign q    = q_q;

`ifdef GS_DIVZERO_EN
   assign divzero = divzero_q;
`else
   assign divzero = 1'b0;
`endif

endmodule
